result_frame_packer: RTL and testbench

Downstream neighbour of the decoding controller. It consumes the controller's per-decode result byte stream and wraps each result in a framed packet for the host link: sync byte, sequence number, 16-bit length, payload and XOR checksum. Payload bytes are the iteration count, the cycle counter high and low bytes, then the correction bytes for every measurement round. A watchdog pads truncated results so the host never sees a partial frame.

---
 rtl/result_frame_packer.sv | 181 ++++++++++++++++++
 tb/tb_result_frame_packer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_frame_packer.sv
// rtl/result_frame_packer.sv - frames decoder result bytes as sync/seq/len/payload/xor-checksum packets
module result_frame_packer #(
    parameter int          GRID_WIDTH_X   = 4,
    parameter int          GRID_WIDTH_Z   = 1,
    parameter int          GRID_WIDTH_U   = 3,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] frames_sent,
    output logic        timeout_error
);
    localparam int CORR = (GRID_WIDTH_X - 1) * GRID_WIDTH_Z
                        + ((GRID_WIDTH_X - 1) * GRID_WIDTH_Z + 1)
                        + GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int          P    = 3 + ((CORR + 7) / 8) * GRID_WIDTH_U;
    localparam logic [15:0] PLEN = 16'(P);
    localparam int          IW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] TMO = IW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_SEQ, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CHK
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [7:0]    seq_q, seq_d;
    logic [7:0]    chk_q, chk_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          pad_q, pad_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [15:0]   frames_q, frames_d;
    logic          terr_q, terr_d;

    logic          slot, room, accept, pad_take;
    logic [7:0]    take_byte;
    logic [IW-1:0] idle_nxt;

    // A new byte may be loaded whenever the output register is empty or draining this cycle.
    assign slot      = !out_valid_q || out_ready;
    assign room      = (state_q == S_PAYLOAD) && (cnt_q < PLEN);
    assign in_ready  = room && !pad_q && slot;
    assign accept    = in_ready && in_valid;
    assign pad_take  = room && pad_q && slot;
    assign take_byte = pad_q ? 8'h00 : in_data;
    assign idle_nxt  = idle_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        seq_d       = seq_q;
        chk_d       = chk_q;
        cnt_d       = cnt_q;
        pad_d       = pad_q;
        idle_d      = idle_q;
        frames_d    = frames_q;
        terr_d      = terr_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    out_data_d  = SYNC_BYTE;
                    out_valid_d = 1'b1;
                    state_d     = S_SYNC;
                end
            end
            S_SYNC: begin
                if (out_ready) begin
                    out_data_d = seq_q;
                    chk_d      = seq_q;
                    state_d    = S_SEQ;
                end
            end
            S_SEQ: begin
                if (out_ready) begin
                    out_data_d = PLEN[15:8];
                    chk_d      = chk_q ^ PLEN[15:8];
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (out_ready) begin
                    out_data_d = PLEN[7:0];
                    chk_d      = chk_q ^ PLEN[7:0];
                    state_d    = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = 16'd0;
                    idle_d      = '0;
                    state_d     = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (accept || pad_take) begin
                    out_data_d  = take_byte;
                    out_valid_d = 1'b1;
                    chk_d       = chk_q ^ take_byte;
                    cnt_d       = cnt_q + 16'd1;
                end else if (slot && (cnt_q == PLEN)) begin
                    out_data_d  = chk_q;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    pad_d       = 1'b0;
                    state_d     = S_CHK;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                // Watchdog counts only genuine input silence before padding kicks in.
                if (accept) begin
                    idle_d = '0;
                end else if (room && !in_valid && !pad_q) begin
                    idle_d = idle_nxt;
                    if (idle_nxt == TMO) begin
                        pad_d  = 1'b1;
                        terr_d = 1'b1;
                    end
                end
            end
            S_CHK: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    seq_d       = seq_q + 8'd1;
                    frames_d    = frames_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            seq_q       <= 8'h00;
            chk_q       <= 8'h00;
            cnt_q       <= 16'd0;
            pad_q       <= 1'b0;
            idle_q      <= '0;
            frames_q    <= 16'd0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            seq_q       <= seq_d;
            chk_q       <= chk_d;
            cnt_q       <= cnt_d;
            pad_q       <= pad_d;
            idle_q      <= idle_d;
            frames_q    <= frames_d;
            terr_q      <= terr_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign busy          = (state_q != S_IDLE);
    assign frames_sent   = frames_q;
    assign timeout_error = terr_q;
endmodule

// File: tb/tb_result_frame_packer.sv
// tb/tb_result_frame_packer.sv - scoreboard bench for result_frame_packer
module tb_result_frame_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic [15:0] frames_sent;
    logic        timeout_error;

    int          checks = 0;
    int          failures = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  pl[9];
    logic [7:0]  exp_seq;
    int          ready_mode;
    bit          mon_en;
    bit          stall_pending;
    logic [8:0]  stall_word;

    result_frame_packer dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .frames_sent(frames_sent),
        .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Host-side ready pattern: 0 steady, 1 toggling, 2 random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        stall_pending = 0;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                stall_pending = 0;
            end else begin
                if (stall_pending) begin
                    check_eq("hold_valid", 32'(out_valid), 32'd1);
                    check_eq("hold_data", 32'({out_last, out_data}), 32'(stall_word));
                end
                stall_pending = 0;
                if (out_valid && !out_ready) begin
                    check_eq("in_ready_stall", 32'(in_ready), 32'd0);
                    stall_pending = 1;
                    stall_word = {out_last, out_data};
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check_eq("extra_byte", 32'(exp_q.size()), 32'd1);
                    else check_eq("byte", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic push_frame();
        logic [7:0] c;
        c = exp_seq ^ 8'h00 ^ 8'h09;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, exp_seq});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'h09});
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({1'b0, pl[i]});
            c = c ^ pl[i];
        end
        exp_q.push_back({1'b1, c});
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic send_payload(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            int g;
            int t;
            bit ok;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (g > 0) in_valid = 1'b0;
            repeat (g) begin @(posedge clk); #2; end
            in_valid = 1'b1;
            in_data  = pl[i];
            t  = 0;
            ok = 0;
            while (!ok && t < 4000) begin
                @(negedge clk);
                if (in_ready) ok = 1;
                @(posedge clk);
                #2;
                t++;
            end
            if (!ok) check_eq("accept_timeout", 32'(ok), 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(posedge clk);
            t++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        exp_seq = 8'h00;
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        ready_mode = 0;
        mon_en = 1;
        exp_seq = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frames", 32'(frames_sent), 32'd0);
        check_eq("rst_terr", 32'(timeout_error), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Frame with payload 01..09, then an all-zero frame (seq 1, chk 08).
        for (int i = 0; i < 9; i++) pl[i] = 8'(i + 1);
        push_frame();
        send_payload(9, 0);
        drain(200);
        check_eq("frames_a1", 32'(frames_sent), 32'd1);
        for (int i = 0; i < 9; i++) pl[i] = 8'h00;
        push_frame();
        send_payload(9, 0);
        drain(200);
        check_eq("frames_a2", 32'(frames_sent), 32'd2);
        check_eq("terr_a", 32'(timeout_error), 32'd0);

        // Backpressure: toggling then random ready, random input gaps.
        do_reset();
        ready_mode = 1;
        for (int i = 0; i < 9; i++) pl[i] = 8'(i + 1);
        push_frame();
        send_payload(9, 3);
        drain(400);
        ready_mode = 2;
        push_frame();
        send_payload(9, 3);
        drain(400);
        check_eq("frames_b", 32'(frames_sent), 32'd2);
        ready_mode = 0;

        // Truncated payload padded after the watchdog expires.
        do_reset();
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        for (int i = 4; i < 9; i++) pl[i] = 8'h00;
        push_frame();
        send_payload(4, 0);
        drain(2000);
        check_eq("terr_c", 32'(timeout_error), 32'd1);
        check_eq("frames_c", 32'(frames_sent), 32'd1);

        // Reset in the middle of a payload drops the frame.
        do_reset();
        mon_en = 0;
        for (int i = 0; i < 9; i++) pl[i] = 8'(8'hC0 + i);
        send_payload(3, 0);
        check_eq("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_frames", 32'(frames_sent), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        exp_seq = 8'h00;
        mon_en = 1;
        push_frame();
        send_payload(9, 0);
        drain(200);
        check_eq("frames_d", 32'(frames_sent), 32'd1);

        // 256 back-to-back frames, then the sequence number wraps to 00.
        do_reset();
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 9; i++) pl[i] = 8'($urandom_range(0, 255));
            push_frame();
            send_payload(9, 0);
        end
        drain(500);
        check_eq("frames_e256", 32'(frames_sent), 32'd256);
        for (int i = 0; i < 9; i++) pl[i] = 8'($urandom_range(0, 255));
        push_frame();
        send_payload(9, 0);
        drain(200);
        check_eq("frames_e257", 32'(frames_sent), 32'd257);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
